motion_scheduler: RTL

MOTION_SCHEDULER -- requirements
Module: motion_scheduler

---
 rtl/motion_scheduler.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/motion_scheduler.sv
// Motion scheduler: accepts forward/turn commands, drives both wheel enables for a fixed
// number of cycles per command, and raises an advisory stuck flag after too many turns in a row.
module motion_scheduler #(
    parameter int unsigned FWD_CYCLES  = 4,
    parameter int unsigned TURN_CYCLES = 6,
    parameter int unsigned STUCK_LIMIT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic front_cmd,
    input  logic turn_cmd,
    input  logic cmd_valid,
    output logic cmd_ready,
    input  logic stuck_clr,
    output logic motor_left,
    output logic motor_right,
    output logic busy,
    output logic stuck
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FORWARD = 2'd1,
        TURN    = 2'd2
    } state_e;

    localparam logic [7:0] FWD_LOAD  = 8'(FWD_CYCLES - 1);
    localparam logic [7:0] TURN_LOAD = 8'(TURN_CYCLES - 1);
    localparam logic [7:0] STUCK_MAX = 8'(STUCK_LIMIT);

    state_e     state_q, state_d;
    logic [7:0] dur_q, dur_d;
    logic [7:0] turn_cnt_q, turn_cnt_d, turn_base_s;
    logic       stuck_q, stuck_d, stuck_base_s;
    logic       motor_left_q, motor_left_d;
    logic       motor_right_q, motor_right_d;
    logic       busy_q, busy_d;
    logic       ready_q, ready_d;
    logic       accept_s, accept_turn_s, accept_fwd_s;

    // ready_q is high exactly in IDLE, so it doubles as the acceptance qualifier.
    assign accept_s      = cmd_valid & ready_q;
    assign accept_turn_s = accept_s & turn_cmd;
    assign accept_fwd_s  = accept_s & front_cmd & ~turn_cmd;

    // Next-state and registered-output decode of the motion FSM.
    always_comb begin
        state_d       = state_q;
        dur_d         = dur_q;
        motor_left_d  = motor_left_q;
        motor_right_d = motor_right_q;
        busy_d        = busy_q;
        ready_d       = ready_q;
        case (state_q)
            IDLE: begin
                if (accept_turn_s) begin
                    state_d       = TURN;
                    dur_d         = TURN_LOAD;
                    motor_left_d  = 1'b1;
                    motor_right_d = 1'b0;
                    busy_d        = 1'b1;
                    ready_d       = 1'b0;
                end else if (accept_fwd_s) begin
                    state_d       = FORWARD;
                    dur_d         = FWD_LOAD;
                    motor_left_d  = 1'b1;
                    motor_right_d = 1'b1;
                    busy_d        = 1'b1;
                    ready_d       = 1'b0;
                end else begin
                    state_d       = IDLE;
                    motor_left_d  = 1'b0;
                    motor_right_d = 1'b0;
                    busy_d        = 1'b0;
                    ready_d       = 1'b1;
                end
            end
            FORWARD, TURN: begin
                if (dur_q == 8'd0) begin
                    state_d       = IDLE;
                    motor_left_d  = 1'b0;
                    motor_right_d = 1'b0;
                    busy_d        = 1'b0;
                    ready_d       = 1'b1;
                end else begin
                    dur_d = dur_q - 8'd1;
                end
            end
            default: begin
                state_d       = IDLE;
                dur_d         = 8'd0;
                motor_left_d  = 1'b0;
                motor_right_d = 1'b0;
                busy_d        = 1'b0;
                ready_d       = 1'b1;
            end
        endcase
    end

    // Turn counter and stuck flag; a coincident clear is applied before the turn increment.
    always_comb begin
        if (stuck_clr) begin
            turn_base_s  = 8'd0;
            stuck_base_s = 1'b0;
        end else begin
            turn_base_s  = turn_cnt_q;
            stuck_base_s = stuck_q;
        end
        if (accept_turn_s) begin
            if (turn_base_s >= STUCK_MAX) begin
                turn_cnt_d = STUCK_MAX;
            end else begin
                turn_cnt_d = turn_base_s + 8'd1;
            end
        end else if (accept_fwd_s) begin
            turn_cnt_d = 8'd0;
        end else begin
            turn_cnt_d = turn_base_s;
        end
        stuck_d = stuck_base_s | (accept_turn_s & (turn_cnt_d == STUCK_MAX));
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            dur_q         <= 8'd0;
            turn_cnt_q    <= 8'd0;
            stuck_q       <= 1'b0;
            motor_left_q  <= 1'b0;
            motor_right_q <= 1'b0;
            busy_q        <= 1'b0;
            ready_q       <= 1'b1;
        end else begin
            state_q       <= state_d;
            dur_q         <= dur_d;
            turn_cnt_q    <= turn_cnt_d;
            stuck_q       <= stuck_d;
            motor_left_q  <= motor_left_d;
            motor_right_q <= motor_right_d;
            busy_q        <= busy_d;
            ready_q       <= ready_d;
        end
    end

    assign cmd_ready   = ready_q;
    assign motor_left  = motor_left_q;
    assign motor_right = motor_right_q;
    assign busy        = busy_q;
    assign stuck       = stuck_q;

endmodule
